demux8_1_tdm: RTL and testbench
===============================

# demux8_1_tdm

Time-division 1-to-8 demultiplexer: the receiving end of a scanned 8:1 mux link. It receives one serial data line on which channel 0..7 occupy consecutive fixed-length slots. After a frame-sync pulse it steps an internal 3-bit slot select in step with the sending mux and latches each slot's bit into its own parallel output. It sits after the combinational `mux8_1` channel scanner and rebuilds the eight parallel lines at the far end.

## Interface
- `DWELL`, default 20: clock cycles per channel slot; legal range 1..65535; counter width is `$clog2(DWELL)`, minimum 1 bit.

- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `EN`  in  1  block enable; low forces IDLE.
- `SYNC`  in  1  frame-start strobe; marks the start of slot 0.
- `D`  in  1  serial TDM data (the sending mux output `O`).
- `O`  out  8  reconstructed channels; `O[i]` holds the last bit captured in slot i.
- `S`  out  3  current slot index (mirrors the sender's select).
- `FRAME`  out  1  one-cycle pulse when slot 7 has been captured.
- `VALID`  out  1  high once a full frame has been captured since the last (re)sync.

## Operation
- States:
  - IDLE: wait for `SYNC`.
  - RUN: count slots.
- Reset (async, `rst_n`=0): state IDLE; `O`=8'h00, `S`=0, dwell count=0, `FRAME`=0, `VALID`=0.
- Priority at each clock edge: `rst_n` > `EN`=0 > `SYNC`=1 > normal counting.
- `EN`=0:
  - State goes to IDLE; `S`=0, count=0, `FRAME`=0, `VALID`=0.
  - `O` holds its value.
- IDLE with `EN`=1 and `SYNC`=1: enter RUN with `S`=0 and count=0. No capture on this edge.
- RUN with `SYNC`=1 (resync):
  - `S`=0, count=0, `VALID`=0; no capture and no `FRAME`.
  - `O` holds.
- RUN, normal counting:
  - If count < `DWELL`-1: count increments.
  - If count == `DWELL`-1:
    - `O[S]` <= `D`; all other `O` bits hold.
    - count <= 0; `S` <= `S`+1, wrapping 7 -> 0.
    - When `S` was 7: `FRAME` <= 1 for exactly one cycle, and `VALID` <= 1.
- `S` increments modulo 8 and RUN continues free-running with no re-sync needed. A fresh `SYNC` at the sender's frame boundary is harmless: `S` and count restart, but `VALID` drops and one frame is lost.
- `DWELL`=1: every RUN cycle captures one slot; a frame takes 8 cycles.
- `D` is sampled synchronously. The block does not synchronize `D` or `SYNC`; the feeder provides that when sources are asynchronous.

## Timing
- All outputs are registered; no combinational input-to-output path.
- `SYNC` sampled at edge E0 -> slot i captured at edge E0 + (i+1)·`DWELL`, taking `D` as set up before that edge.
- `O[i]` changes at edge E0 + (i+1)·`DWELL` and is stable for 8·`DWELL` cycles until its next slot.
- `FRAME` is high for the cycle after edge E0 + 8·`DWELL`; after that it pulses every 8·`DWELL` cycles.
- `VALID` rises together with the first `FRAME`.
- `S` value during cycles (E0 + k·`DWELL`, E0 + (k+1)·`DWELL`] is k mod 8.
- Latency from the last bit of a frame to a complete `O` is 0 cycles after the capture edge; `FRAME` is asserted in that same cycle.
- Reset mid-frame: outputs clear immediately (async). After `rst_n` deasserts, the block waits for `SYNC`.

## Test plan
- Reset: assert `rst_n`=0 mid-RUN -> `O`=00, `S`=0, `FRAME`=0, `VALID`=0 without waiting for a clock; after release, `D` toggling without `SYNC` leaves `O`=00.
- Basic frame, `DWELL`=4: `SYNC` at E0, drive `D` slot pattern 1,0,1,1,0,0,1,0 (slot 0 first) -> `O`=8'b0100_1101 at E0+32, `FRAME` is one cycle high after E0+32, `VALID`=1, `S` steps 0..7 every 4 cycles.
- Wrap and hold, `DWELL`=4: continue with inverted pattern -> after E0+36 only `O[0]` has changed (to 0); at E0+64 `O`=8'b1011_0010; second `FRAME` pulse 32 cycles after the first.
- Resync mid-frame: `SYNC`=1 at E0+13 -> `S`=0, `VALID`=0, `O` holds `O[2:0]` from before; the next capture is at E0+17 into `O[0]`; `FRAME` occurs at E0+45.
- Enable drop: `EN`=0 for 5 cycles during slot 3 -> `S`=0, `O` unchanged, no `FRAME`; after `EN`=1, no capture occurs until `SYNC`.
- Loopback, `DWELL`=20: drive `D` from a `mux8_1` whose `S` increments every 20 cycles, with `SYNC` at its `S`=0 start and 256 random input vectors -> each `FRAME` shows `O` equal to the mux inputs sampled at the end of each slot.

Source files
------------

// File: rtl/demux8_1_tdm.sv
// Receiving end of a scanned 8:1 TDM link: after SYNC, steps a 3-bit slot index every DWELL cycles
// and latches the serial bit at the end of each slot into its parallel output; all outputs registered.
module demux8_1_tdm #(
  parameter int unsigned DWELL = 20
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       EN,
  input  logic       SYNC,
  input  logic       D,
  output logic [7:0] O,
  output logic [2:0] S,
  output logic       FRAME,
  output logic       VALID
);

  localparam int unsigned CW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DWELL - 1);

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic [2:0]    s_q;
  logic [7:0]    o_q;
  logic          frame_q;
  logic          valid_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      s_q     <= 3'd0;
      o_q     <= 8'h00;
      frame_q <= 1'b0;
      valid_q <= 1'b0;
    end else if (!EN) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      s_q     <= 3'd0;
      frame_q <= 1'b0;
      valid_q <= 1'b0;
    end else if (SYNC) begin
      // Start or restart of a frame; the slot in flight is discarded.
      state_q <= RUN;
      cnt_q   <= '0;
      s_q     <= 3'd0;
      frame_q <= 1'b0;
      valid_q <= 1'b0;
    end else if (state_q == RUN) begin
      frame_q <= 1'b0;
      if (cnt_q == CNT_LAST) begin
        o_q[s_q] <= D;
        cnt_q    <= '0;
        s_q      <= s_q + 3'd1;
        if (s_q == 3'd7) begin
          frame_q <= 1'b1;
          valid_q <= 1'b1;
        end
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end
    end else begin
      frame_q <= 1'b0;
    end
  end

  assign O     = o_q;
  assign S     = s_q;
  assign FRAME = frame_q;
  assign VALID = valid_q;

endmodule

// File: tb/tb_demux8_1_tdm.sv
// Bench for demux8_1_tdm: a DWELL=4 instance for directed frame/resync/enable/reset cases and a
// DWELL=20 instance fed by a behavioural 8:1 scanning mux, both tracked by a slot-time reference model.
module tb_demux8_1_tdm;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en_a = 1'b0, sync_a = 1'b0, d_a = 1'b0;
  logic       en_b = 1'b0, sync_b = 1'b0, d_b = 1'b0;
  logic [7:0] o_a, o_b;
  logic [2:0] s_a, s_b;
  logic       frame_a, frame_b, valid_a, valid_b;

  int n_chk = 0;
  int n_err = 0;

  demux8_1_tdm #(.DWELL(4)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .EN(en_a), .SYNC(sync_a), .D(d_a),
    .O(o_a), .S(s_a), .FRAME(frame_a), .VALID(valid_a)
  );

  demux8_1_tdm #(.DWELL(20)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .EN(en_b), .SYNC(sync_b), .D(d_b),
    .O(o_b), .S(s_b), .FRAME(frame_b), .VALID(valid_b)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: elapsed cycles since SYNC; slot boundaries fall on multiples of the dwell.
  bit         m_run[2];
  int         m_t[2];
  logic [7:0] m_o[2];
  bit         m_frame[2];
  bit         m_valid[2];

  task automatic model_edge(input int k, input int dw, input logic en, input logic sync, input logic d);
    int slot;
    m_frame[k] = 1'b0;
    if (!en) begin
      m_run[k] = 1'b0; m_t[k] = 0; m_valid[k] = 1'b0;
    end else if (sync) begin
      m_run[k] = 1'b1; m_t[k] = 0; m_valid[k] = 1'b0;
    end else if (m_run[k]) begin
      m_t[k] = m_t[k] + 1;
      if (m_t[k] % dw == 0) begin
        slot = (m_t[k] / dw - 1) % 8;
        m_o[k][slot] = d;
        if (slot == 7) begin
          m_frame[k] = 1'b1;
          m_valid[k] = 1'b1;
        end
      end
    end
  endtask

  function automatic int m_s(input int k, input int dw);
    return m_run[k] ? (m_t[k] / dw) % 8 : 0;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 2; k++) begin
        m_run[k] = 1'b0; m_t[k] = 0; m_o[k] = 8'h00; m_frame[k] = 1'b0; m_valid[k] = 1'b0;
      end
    end else begin
      model_edge(0, 4, en_a, sync_a, d_a);
      model_edge(1, 20, en_b, sync_b, d_b);
    end
  end

  always @(negedge clk) begin
    check("a_O", 32'(o_a), 32'(m_o[0]));
    check("a_S", 32'(s_a), 32'(m_s(0, 4)));
    check("a_FRAME", 32'(frame_a), 32'(m_frame[0]));
    check("a_VALID", 32'(valid_a), 32'(m_valid[0]));
    check("b_O", 32'(o_b), 32'(m_o[1]));
    check("b_S", 32'(s_b), 32'(m_s(1, 20)));
    check("b_FRAME", 32'(frame_b), 32'(m_frame[1]));
    check("b_VALID", 32'(valid_b), 32'(m_valid[1]));
  end

  task automatic cyc();
    @(negedge clk);
  endtask

  logic [7:0] pat;
  logic [7:0] o_hold;
  logic [7:0] vec;
  logic [7:0] exp_bits;

  initial begin
    pat = 8'b0100_1101;
    repeat (3) cyc();
    check("rst_O", 32'(o_a), 32'h00);
    check("rst_VALID", 32'(valid_a), 32'h0);
    rst_n = 1'b1;
    cyc();

    // Basic frame, DWELL=4
    en_a = 1'b1; sync_a = 1'b1;
    cyc();
    sync_a = 1'b0;
    for (int t = 0; t < 32; t++) begin
      d_a = pat[t / 4];
      check("basic_S", 32'(s_a), 32'((t / 4) % 8));
      check("basic_noframe", 32'(frame_a), 32'h0);
      cyc();
    end
    check("basic_O", 32'(o_a), 32'h4D);
    check("basic_FRAME", 32'(frame_a), 32'h1);
    check("basic_VALID", 32'(valid_a), 32'h1);

    // Wrap with inverted pattern
    for (int t = 32; t < 64; t++) begin
      d_a = ~pat[(t - 32) / 4];
      if (t == 33) check("wrap_frame_off", 32'(frame_a), 32'h0);
      if (t == 36) check("wrap_O0_only", 32'(o_a), 32'h4C);
      cyc();
    end
    check("wrap_O", 32'(o_a), 32'hB2);
    check("wrap_FRAME", 32'(frame_a), 32'h1);

    // Resync at frame offset 13: slots 0..2 captured as 1,0,1 first
    for (int t = 64; t < 77; t++) begin
      d_a = (((t - 64) / 4) == 1) ? 1'b0 : 1'b1;
      if (t == 76) sync_a = 1'b1;
      cyc();
    end
    sync_a = 1'b0;
    check("resync_S", 32'(s_a), 32'h0);
    check("resync_VALID", 32'(valid_a), 32'h0);
    check("resync_O", 32'(o_a), 32'hB5);
    for (int k = 0; k < 32; k++) begin
      d_a = 1'($urandom);
      cyc();
      check("resync_FRAME", 32'(frame_a), (k == 31) ? 32'h1 : 32'h0);
    end
    check("resync_VALID_back", 32'(valid_a), 32'h1);

    // Enable drop during slot 3
    for (int k = 0; k < 13; k++) begin
      d_a = 1'($urandom);
      cyc();
    end
    check("pre_drop_S", 32'(s_a), 32'h3);
    o_hold = m_o[0];
    en_a = 1'b0;
    repeat (5) begin
      d_a = ~d_a;
      cyc();
      check("drop_S", 32'(s_a), 32'h0);
      check("drop_FRAME", 32'(frame_a), 32'h0);
    end
    en_a = 1'b1;
    for (int k = 0; k < 40; k++) begin
      d_a = ~d_a;
      cyc();
    end
    check("drop_O_hold", 32'(o_a), 32'(o_hold));
    check("drop_nosync_S", 32'(s_a), 32'h0);

    // Asynchronous reset mid-run
    sync_a = 1'b1;
    cyc();
    sync_a = 1'b0;
    for (int k = 0; k < 20; k++) begin
      d_a = 1'($urandom);
      cyc();
    end
    #2 rst_n = 1'b0;
    #1;
    check("arst_O", 32'(o_a), 32'h00);
    check("arst_S", 32'(s_a), 32'h0);
    check("arst_FRAME", 32'(frame_a), 32'h0);
    check("arst_VALID", 32'(valid_a), 32'h0);
    cyc();
    rst_n = 1'b1;
    for (int k = 0; k < 30; k++) begin
      d_a = ~d_a;
      cyc();
    end
    check("post_rst_O", 32'(o_a), 32'h00);
    en_a = 1'b0;

    // Loopback, DWELL=20: a scanning mux with a fresh random input vector every slot
    en_b = 1'b1; sync_b = 1'b1;
    exp_bits = 8'h00;
    vec = 8'h00;
    cyc();
    sync_b = 1'b0;
    for (int t = 0; t <= 256 * 20; t++) begin
      if (t > 0 && t % 160 == 0) begin
        check("loop_FRAME", 32'(frame_b), 32'h1);
        check("loop_O", 32'(o_b), 32'(exp_bits));
        check("loop_VALID", 32'(valid_b), 32'h1);
      end
      if (t == 256 * 20) break;
      if (t % 20 == 0) begin
        vec = 8'($urandom);
        exp_bits[(t / 20) % 8] = vec[(t / 20) % 8];
      end
      d_b = vec[(t / 20) % 8];
      cyc();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
